// File: rtl/matmul_step_seq_if.sv
// Controller <-> step sequencer bus for matmul_step_seq.
// Carries stall_cnt only when STATUS_STALL_CNT_EN is defined.
interface matmul_step_seq_if #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4
) ();
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = $clog2(M * N * K + 1);

  logic          start;
  logic          clear;
  logic          multiply;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [KW-1:0] kidx;
  logic          step_valid;
  logic          acc_clr;
  logic          acc_wr;
  logic [TW-1:0] step_cnt;
  logic          busy;
  logic          done;
`ifdef STATUS_STALL_CNT_EN
  logic [TW-1:0] stall_cnt;
`endif

  modport master (
    output start, clear, multiply,
    input  row, col, kidx, step_valid, acc_clr, acc_wr, step_cnt, busy, done
`ifdef STATUS_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, clear, multiply,
    output row, col, kidx, step_valid, acc_clr, acc_wr, step_cnt, busy, done
`ifdef STATUS_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/matmul_step_seq.sv
// Walks (row, col, k) of an MxK by KxN multiply, one product step per enabled cycle.
// Optional STATUS_STALL_CNT_EN adds a saturating count of stalled RUN cycles.
//
// state | meaning
// IDLE  | waiting for start; indices and step count zero
// RUN   | stepping on multiply=1, holding on multiply=0
// DONE  | all M*N*K steps complete; waits for start/clear
module matmul_step_seq #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4
) (
  input logic             clk,
  input logic             reset,
  matmul_step_seq_if.slave bus
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = $clog2(M * N * K + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] kidx_q, kidx_d;
  logic [TW-1:0] cnt_q, cnt_d;
`ifdef STATUS_STALL_CNT_EN
  logic [TW-1:0] stall_q, stall_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      kidx_q  <= '0;
      cnt_q   <= '0;
`ifdef STATUS_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kidx_q  <= kidx_d;
      cnt_q   <= cnt_d;
`ifdef STATUS_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    kidx_d  = kidx_q;
    cnt_d   = cnt_q;
`ifdef STATUS_STALL_CNT_EN
    stall_d = stall_q;
`endif
    if (bus.clear || (bus.start && state_q != RUN)) begin
      state_d = bus.clear ? IDLE : RUN;
      row_d   = '0;
      col_d   = '0;
      kidx_d  = '0;
      cnt_d   = '0;
`ifdef STATUS_STALL_CNT_EN
      stall_d = '0;
`endif
    end else if (state_q == RUN) begin
      if (bus.multiply) begin
        cnt_d = cnt_q + 1'b1;
        // k fastest, then col, then row; exact-bound wrap for non-power-of-2 dims
        if (kidx_q != K_LAST) begin
          kidx_d = kidx_q + 1'b1;
        end else begin
          kidx_d = '0;
          if (col_q != COL_LAST) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q != ROW_LAST) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d   = '0;
              state_d = DONE;
            end
          end
        end
      end
`ifdef STATUS_STALL_CNT_EN
      else if (stall_q != {TW{1'b1}}) begin
        stall_d = stall_q + 1'b1;
      end
`endif
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.kidx       = kidx_q;
  assign bus.step_cnt   = cnt_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.step_valid = (state_q == RUN) && bus.multiply;
  assign bus.acc_clr    = bus.step_valid && (kidx_q == '0);
  assign bus.acc_wr     = bus.step_valid && (kidx_q == K_LAST);
`ifdef STATUS_STALL_CNT_EN
  assign bus.stall_cnt  = stall_q;
`endif
endmodule

// File: tb/tb_matmul_step_seq.sv
// Bench for matmul_step_seq: three dimension sets driven in lockstep, checked
// every cycle against an index-arithmetic reference model.
module tb_matmul_step_seq;
  logic clk = 1'b0;
  logic reset, start, clear, multiply;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  matmul_step_seq_if #(.M(2), .N(2), .K(2)) b0 ();
  matmul_step_seq_if #(.M(4), .N(4), .K(4)) b1 ();
  matmul_step_seq_if #(.M(3), .N(1), .K(3)) b2 ();

  matmul_step_seq #(.M(2), .N(2), .K(2)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  matmul_step_seq #(.M(4), .N(4), .K(4)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
  matmul_step_seq #(.M(3), .N(1), .K(3)) d2 (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b0.start = start; assign b0.clear = clear; assign b0.multiply = multiply;
  assign b1.start = start; assign b1.clear = clear; assign b1.multiply = multiply;
  assign b2.start = start; assign b2.clear = clear; assign b2.multiply = multiply;

  logic [31:0] o_row[3], o_col[3], o_k[3], o_cnt[3], o_stall[3];
  logic        o_sv[3], o_clr[3], o_wr[3], o_busy[3], o_done[3];

  assign o_row[0] = 32'(b0.row);  assign o_col[0] = 32'(b0.col);  assign o_k[0] = 32'(b0.kidx);
  assign o_row[1] = 32'(b1.row);  assign o_col[1] = 32'(b1.col);  assign o_k[1] = 32'(b1.kidx);
  assign o_row[2] = 32'(b2.row);  assign o_col[2] = 32'(b2.col);  assign o_k[2] = 32'(b2.kidx);
  assign o_cnt[0] = 32'(b0.step_cnt); assign o_cnt[1] = 32'(b1.step_cnt); assign o_cnt[2] = 32'(b2.step_cnt);
  assign o_sv[0] = b0.step_valid; assign o_clr[0] = b0.acc_clr; assign o_wr[0] = b0.acc_wr;
  assign o_sv[1] = b1.step_valid; assign o_clr[1] = b1.acc_clr; assign o_wr[1] = b1.acc_wr;
  assign o_sv[2] = b2.step_valid; assign o_clr[2] = b2.acc_clr; assign o_wr[2] = b2.acc_wr;
  assign o_busy[0] = b0.busy; assign o_done[0] = b0.done;
  assign o_busy[1] = b1.busy; assign o_done[1] = b1.done;
  assign o_busy[2] = b2.busy; assign o_done[2] = b2.done;
`ifdef STATUS_STALL_CNT_EN
  assign o_stall[0] = 32'(b0.stall_cnt);
  assign o_stall[1] = 32'(b1.stall_cnt);
  assign o_stall[2] = 32'(b2.stall_cnt);
`else
  assign o_stall[0] = '0; assign o_stall[1] = '0; assign o_stall[2] = '0;
`endif

  // Reference model: phase (0 idle, 1 run, 2 done) and number of completed steps.
  int md[3] = '{2, 4, 3};
  int nd[3] = '{2, 4, 1};
  int kd[3] = '{2, 4, 3};
  int ph[3], sc[3], stl[3];

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic check_inst(input int i);
    int er, ec, ek;
    logic sv;
    er = (ph[i] == 1) ? sc[i] / (nd[i] * kd[i]) : 0;
    ec = (ph[i] == 1) ? (sc[i] / kd[i]) % nd[i] : 0;
    ek = (ph[i] == 1) ? sc[i] % kd[i] : 0;
    sv = (ph[i] == 1) && multiply;
    chk("row", i, o_row[i], er);
    chk("col", i, o_col[i], ec);
    chk("kidx", i, o_k[i], ek);
    chk("step_cnt", i, o_cnt[i], sc[i]);
    chk("busy", i, 32'(o_busy[i]), 32'(ph[i] == 1));
    chk("done", i, 32'(o_done[i]), 32'(ph[i] == 2));
    chk("step_valid", i, 32'(o_sv[i]), 32'(sv));
    chk("acc_clr", i, 32'(o_clr[i]), 32'(sv && ek == 0));
    chk("acc_wr", i, 32'(o_wr[i]), 32'(sv && ek == kd[i] - 1));
`ifdef STATUS_STALL_CNT_EN
    chk("stall_cnt", i, o_stall[i], stl[i]);
`endif
  endtask

  task automatic model_edge(input int i, input logic r, input logic c, input logic s, input logic m);
    int total, smax;
    total = md[i] * nd[i] * kd[i];
    smax  = (1 << $clog2(total + 1)) - 1;
    if (!r || c) begin
      ph[i] = 0; sc[i] = 0; stl[i] = 0;
    end else if (s && ph[i] != 1) begin
      ph[i] = 1; sc[i] = 0; stl[i] = 0;
    end else if (ph[i] == 1) begin
      if (m) begin
        sc[i]++;
        if (sc[i] == total) ph[i] = 2;
      end else if (stl[i] < smax) begin
        stl[i]++;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic s, input logic m);
    @(negedge clk);
    reset = r; clear = c; start = s; multiply = m;
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, r, c, s, m);
  endtask

  task automatic mults(input int n);
    for (int j = 0; j < n; j++) step(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 3; i++) begin ph[i] = 0; sc[i] = 0; stl[i] = 0; end
    reset = 1'b0; start = 1'b1; clear = 1'b0; multiply = 1'b1;
    @(posedge clk);
    // Reset dominates start/multiply
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // 2x2x2 full walk; 3x1x3 needs one extra step
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mults(8);
    #1;
    chk("t2_done", 0, 32'(o_done[0]), 32'd1);
    chk("t2_cnt", 0, o_cnt[0], 32'd8);
    mults(1);
    #1;
    chk("t4_done", 2, 32'(o_done[2]), 32'd1);
    chk("t4_cnt", 2, o_cnt[2], 32'd9);

    // 4x4x4 with multiply toggling 0,1
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 128; j++) step(1'b1, 1'b0, 1'b0, 1'(j % 2));
    #1;
    chk("t3_done", 1, 32'(o_done[1]), 32'd1);
    chk("t3_cnt", 1, o_cnt[1], 32'd64);
`ifdef STATUS_STALL_CNT_EN
    chk("t3_stall", 1, o_stall[1], 32'd64);
`endif

    // Random multiply with occasional start (ignored in RUN, restarts from DONE)
    step(1'b1, 1'b0, 1'b1, 1'b0);
    budget = 0;
    while (ph[1] != 2 && budget < 2000) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
      budget++;
    end
    chk("rand_budget", 1, 32'(ph[1] == 2), 32'd1);

    // clear together with start mid-run, then a clean run
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mults(5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t5_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("t5_cnt", 0, o_cnt[0], 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mults(8);
    #1;
    chk("t5_done", 0, 32'(o_done[0]), 32'd1);

    // start in RUN ignored; start in DONE restarts; reset mid-run
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mults(3);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    mults(4);
    #1;
    chk("t6_done", 0, 32'(o_done[0]), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t6_restart_cnt", 0, o_cnt[0], 32'd0);
    chk("t6_restart_busy", 0, 32'(o_busy[0]), 32'd1);
    mults(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t6_reset_busy", 1, 32'(o_busy[1]), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
